// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
//   Receive-side checker for a VGA output bus (hsync, vsync, 2-bit R/G/B).
//   It measures line and frame timing and recovers the active-pixel window.
//   It locks to the expected raster and folds every active pixel of a frame
//   into a 16-bit CRC-style signature, so frames can be compared without
//   storing them.
//
//   Optional feature: define MON_BLANK_CHECK_EN to treat any nonzero RGB
//   outside the active window (including sync periods) as a timing mismatch.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   synchronous active-low reset
//   hsync_in     in   horizontal sync, active low
//   vsync_in     in   vertical sync, active low
//   r_in/g_in/b_in in 2-bit pixel colour each
//   locked       out  raster matches expected timing
//   line_len     out  last measured hsync period in clocks (saturates 1023)
//   hsync_width  out  last hsync low width in clocks
//   frame_lines  out  hsync falls counted in last frame
//   vsync_width  out  hsync falls counted while vsync was low
//   frame_sig    out  signature of last complete frame
//   frame_done   out  one-cycle pulse when frame_sig/frame_lines update
//   err_pulse    out  one-cycle pulse on timing mismatch while locked
//   err_count    out  saturating count of err_pulse events
//
// Latency: a pin value captured into the first stage at edge n produces its
// edge strobe at edge n+1 and updates the measurement outputs at edge n+2.
module vga_frame_monitor #(
    parameter int H_TOTAL          = 800,
    parameter int V_TOTAL          = 525,
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int H_SYNC_TO_ACTIVE = 144,
    parameter int V_SYNC_TO_ACTIVE = 35
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  r_in,
    input  logic [1:0]  g_in,
    input  logic [1:0]  b_in,
    output logic        locked,
    output logic [9:0]  line_len,
    output logic [9:0]  hsync_width,
    output logic [9:0]  frame_lines,
    output logic [9:0]  vsync_width,
    output logic [15:0] frame_sig,
    output logic        frame_done,
    output logic        err_pulse,
    output logic [7:0]  err_count
);

    localparam logic [9:0]  CNT_MAX   = 10'h3FF;
    localparam logic [9:0]  H_TOTAL_L = 10'(H_TOTAL);
    localparam logic [9:0]  V_TOTAL_L = 10'(V_TOTAL);
    localparam logic [10:0] X_LO      = 11'(H_SYNC_TO_ACTIVE);
    localparam logic [10:0] X_HI      = 11'(H_SYNC_TO_ACTIVE + H_ACTIVE);
    localparam logic [10:0] Y_LO      = 11'(V_SYNC_TO_ACTIVE);
    localparam logic [10:0] Y_HI      = 11'(V_SYNC_TO_ACTIVE + V_ACTIVE);
    localparam logic [15:0] SIG_SEED  = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // ---------------- input stage ----------------
    logic       hs_s1_reg, hs_s2_reg, vs_s1_reg, vs_s2_reg;
    logic [5:0] rgb_s1_reg, rgb_s2_reg;
    logic       hs_fall_reg, hs_rise_reg, vs_fall_reg, vs_rise_reg;

    // Edge strobes are registered so that after each edge the strobe and the
    // s2 level/pixel describe the same pin sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_s1_reg   <= 1'b0;
            hs_s2_reg   <= 1'b0;
            vs_s1_reg   <= 1'b0;
            vs_s2_reg   <= 1'b0;
            rgb_s1_reg  <= 6'd0;
            rgb_s2_reg  <= 6'd0;
            hs_fall_reg <= 1'b0;
            hs_rise_reg <= 1'b0;
            vs_fall_reg <= 1'b0;
            vs_rise_reg <= 1'b0;
        end else begin
            hs_s1_reg   <= hsync_in;
            hs_s2_reg   <= hs_s1_reg;
            vs_s1_reg   <= vsync_in;
            vs_s2_reg   <= vs_s1_reg;
            rgb_s1_reg  <= {r_in, g_in, b_in};
            rgb_s2_reg  <= rgb_s1_reg;
            hs_fall_reg <= hs_s2_reg & ~hs_s1_reg;
            hs_rise_reg <= ~hs_s2_reg & hs_s1_reg;
            vs_fall_reg <= vs_s2_reg & ~vs_s1_reg;
            vs_rise_reg <= ~vs_s2_reg & vs_s1_reg;
        end
    end

    // ---------------- measurement datapath ----------------
    logic [9:0]  hcnt_reg, lcnt_reg, hwid_reg, vwid_reg;
    logic [15:0] sig_reg;
    logic [9:0]  hcnt_inc, lcnt_inc, hwid_inc, vwid_inc;
    logic        pixel_active;
    logic [15:0] sig_step;

    assign hcnt_inc = (hcnt_reg == CNT_MAX) ? CNT_MAX : hcnt_reg + 10'd1;
    assign hwid_inc = (hwid_reg == CNT_MAX) ? CNT_MAX : hwid_reg + 10'd1;
    assign vwid_inc = (vwid_reg == CNT_MAX) ? CNT_MAX : vwid_reg + 10'd1;
    // Line count including an hsync fall in this very cycle, so a frame
    // closed together with a line accounts for that line.
    assign lcnt_inc = (hs_fall_reg && lcnt_reg != CNT_MAX) ? lcnt_reg + 10'd1 : lcnt_reg;

    assign pixel_active = ({1'b0, hcnt_reg} >= X_LO) && ({1'b0, hcnt_reg} < X_HI) &&
                          ({1'b0, lcnt_reg} >= Y_LO) && ({1'b0, lcnt_reg} < Y_HI);

    assign sig_step = {sig_reg[14:0], 1'b0} ^ (sig_reg[15] ? 16'h1021 : 16'h0000) ^
                      {10'd0, rgb_s2_reg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_reg    <= 10'd0;
            lcnt_reg    <= 10'd0;
            hwid_reg    <= 10'd0;
            vwid_reg    <= 10'd0;
            sig_reg     <= SIG_SEED;
            line_len    <= 10'd0;
            hsync_width <= 10'd0;
            frame_lines <= 10'd0;
            vsync_width <= 10'd0;
            frame_sig   <= 16'd0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= vs_fall_reg;

            if (hs_fall_reg) begin
                line_len <= hcnt_inc;
                hcnt_reg <= 10'd0;
            end else begin
                hcnt_reg <= hcnt_inc;
            end

            // The fall cycle itself is the first low clock of the pulse.
            if (hs_fall_reg) begin
                hwid_reg <= 10'd1;
            end else if (!hs_s2_reg) begin
                hwid_reg <= hwid_inc;
            end
            if (hs_rise_reg) begin
                hsync_width <= hwid_reg;
            end

            if (vs_fall_reg) begin
                vwid_reg <= {9'd0, hs_fall_reg};
            end else if (!vs_s2_reg && hs_fall_reg) begin
                vwid_reg <= vwid_inc;
            end
            if (vs_rise_reg) begin
                vsync_width <= vwid_reg;
            end

            if (vs_fall_reg) begin
                frame_lines <= lcnt_inc;
                lcnt_reg    <= 10'd0;
                frame_sig   <= sig_reg;
                sig_reg     <= SIG_SEED;
            end else begin
                lcnt_reg <= lcnt_inc;
                if (pixel_active) begin
                    sig_reg <= sig_step;
                end
            end
        end
    end

    // ---------------- lock FSM ----------------
    state_t state_reg, state_next;
    logic   mismatch_reg, mismatch_next;
    logic   err_event;
    logic   line_bad, frame_bad, hcnt_sat, blank_bad;

    assign line_bad  = hs_fall_reg && (hcnt_inc != H_TOTAL_L);
    assign frame_bad = vs_fall_reg && (lcnt_inc != V_TOTAL_L);
    assign hcnt_sat  = (hcnt_reg == CNT_MAX);

`ifdef MON_BLANK_CHECK_EN
    assign blank_bad = !pixel_active && (rgb_s2_reg != 6'd0);
`else
    assign blank_bad = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        mismatch_next = mismatch_reg;
        err_event     = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (vs_fall_reg) begin
                    state_next    = VERIFY;
                    mismatch_next = 1'b0;
                end
            end
            VERIFY: begin
                if (line_bad || blank_bad) begin
                    mismatch_next = 1'b1;
                end
                if (vs_fall_reg) begin
                    // Same-cycle line mismatch must still block the lock.
                    if (!(mismatch_reg || line_bad || blank_bad) && lcnt_inc == V_TOTAL_L) begin
                        state_next = LOCKED;
                    end
                    mismatch_next = 1'b0;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad || hcnt_sat || blank_bad) begin
                    err_event  = 1'b1;
                    state_next = SEARCH;
                end
            end
            default: begin
                state_next    = SEARCH;
                mismatch_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= SEARCH;
            mismatch_reg <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            state_reg    <= state_next;
            mismatch_reg <= mismatch_next;
            err_pulse    <= err_event;
            if (err_event && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign locked = (state_reg == LOCKED);

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Testbench for vga_frame_monitor using a reduced raster (40 x 20 clocks,
// 16 x 8 active) so a dozen frames fit in a short run. Expected results are
// pushed into queues by the stimulus; a monitor pops and compares whenever
// the DUT pulses frame_done or err_pulse.
module tb_vga_frame_monitor;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HA  = 16;
    localparam int VA  = 8;
    localparam int HS  = 10;
    localparam int VS  = 4;
    localparam int HSW = 4;
    localparam int VSW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsync_in, vsync_in;
    logic [1:0]  r_in, g_in, b_in;
    logic        locked, frame_done, err_pulse;
    logic [9:0]  line_len, hsync_width, frame_lines, vsync_width;
    logic [15:0] frame_sig;
    logic [7:0]  err_count;

    vga_frame_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_SYNC_TO_ACTIVE(HS), .V_SYNC_TO_ACTIVE(VS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .locked(locked),
        .line_len(line_len), .hsync_width(hsync_width), .frame_lines(frame_lines),
        .vsync_width(vsync_width), .frame_sig(frame_sig), .frame_done(frame_done),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lines;
        bit          lk;
        int          ll;      // -1: not checked
        int          hw;      // -1: not checked
        int          vw;      // -1: not checked
        bit          chk_sig;
        logic [15:0] sig;
    } fd_exp_t;

    fd_exp_t fd_q[$];
    int      err_q[$];
    int      checks = 0;
    int      errors = 0;
    logic [15:0] m0, m3f;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sig_model(input logic [5:0] p, input int n);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'd0, p};
        end
        return s;
    endfunction

    task automatic push_fd(input int lines, input bit lk, input int ll, input int hw,
                           input int vw, input bit cs, input logic [15:0] sig);
        fd_exp_t e;
        e.lines = lines; e.lk = lk; e.ll = ll; e.hw = hw; e.vw = vw;
        e.chk_sig = cs; e.sig = sig;
        fd_q.push_back(e);
    endtask

    task automatic check_reset();
        chk("rst_locked", int'(locked), 0);
        chk("rst_line_len", int'(line_len), 0);
        chk("rst_hsync_width", int'(hsync_width), 0);
        chk("rst_frame_lines", int'(frame_lines), 0);
        chk("rst_vsync_width", int'(vsync_width), 0);
        chk("rst_frame_sig", int'(frame_sig), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        chk("rst_err_count", int'(err_count), 0);
    endtask

    // One line of len clocks; line k counted from the vsync-fall line.
    // Pin cycle c maps to x = c-1 inside the monitor.
    task automatic drive_line(input int k, input int len, input logic [5:0] pix,
                              input int inj_c, input int rst_c);
        logic [5:0] rgb;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (c == rst_c + 1) begin
                check_reset();
                rst_n = 1'b1;
            end
            if (c == rst_c) rst_n = 1'b0;
            hsync_in = (c < HSW) ? 1'b0 : 1'b1;
            vsync_in = (k < VSW) ? 1'b0 : 1'b1;
            rgb = (c >= HS + 1 && c <= HS + HA && k >= VS && k < VS + VA) ? pix : 6'd0;
            if (c == inj_c) rgb = 6'h01;
            {r_in, g_in, b_in} = rgb;
        end
    endtask

    task automatic frame(input logic [5:0] pix, input int bad_k, input int inj_k,
                         input int rst_k);
        for (int k = 0; k < VT; k++) begin
            drive_line(k, (k == bad_k) ? HT - 1 : HT, pix,
                       (k == inj_k) ? 31 : -1, (k == rst_k) ? 20 : -10);
        end
    endtask

    // Scoreboard monitor
    initial begin
        fd_exp_t e;
        int      ec;
        forever begin
            @(negedge clk);
            if (frame_done) begin
                $display("frame_done lines=%0d locked=%0d line_len=%0d sig=%h",
                         frame_lines, locked, line_len, frame_sig);
                if (fd_q.size() == 0) begin
                    chk("unexpected_frame_done", 1, 0);
                end else begin
                    e = fd_q.pop_front();
                    chk("frame_lines", int'(frame_lines), e.lines);
                    chk("locked_at_frame", int'(locked), int'(e.lk));
                    if (e.ll >= 0) chk("line_len", int'(line_len), e.ll);
                    if (e.hw >= 0) chk("hsync_width", int'(hsync_width), e.hw);
                    if (e.vw >= 0) chk("vsync_width", int'(vsync_width), e.vw);
                    if (e.chk_sig) chk("frame_sig", int'(frame_sig), int'(e.sig));
                end
            end
            if (err_pulse) begin
                $display("err_pulse err_count=%0d locked=%0d", err_count, locked);
                if (err_q.size() == 0) begin
                    chk("unexpected_err_pulse", 1, 0);
                end else begin
                    ec = err_q.pop_front();
                    chk("err_count", int'(err_count), ec);
                    chk("locked_after_err", int'(locked), 0);
                end
            end
        end
    end

    initial begin
        bit lk_h;
        m0  = sig_model(6'h00, HA * VA);
        m3f = sig_model(6'h3F, HA * VA);

        rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        r_in = 2'd0; g_in = 2'd0; b_in = 2'd0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Frame A0: first vsync fall after reset -> VERIFY
        push_fd(1, 1'b0, -1, -1, -1, 1'b0, 16'h0);
        frame(6'h00, -1, -1, -1);
        // Frame A1: A0 verified -> LOCKED
        push_fd(VT, 1'b1, HT, HSW, VSW, 1'b0, 16'h0);
        frame(6'h00, -1, -1, -1);
        // Frame B (3F): closes A1 with the all-zero signature
        push_fd(VT, 1'b1, HT, -1, -1, 1'b1, m0);
        frame(6'h3F, -1, -1, -1);
        // Frame C: closes B; line 10 is one clock short -> error
        push_fd(VT, 1'b1, -1, -1, -1, 1'b1, m3f);
        err_q.push_back(1);
        frame(6'h00, 10, -1, -1);
        // Frames D, E: relock over two clean frames
        push_fd(VT, 1'b0, HT, -1, -1, 1'b0, 16'h0);
        frame(6'h00, -1, -1, -1);
        push_fd(VT, 1'b1, -1, -1, -1, 1'b0, 16'h0);
        frame(6'h00, -1, -1, -1);
        // Frame F: 5 lines then hsync stuck high -> saturation error
        push_fd(VT, 1'b1, -1, HSW, VSW, 1'b1, m0);
        err_q.push_back(2);
        for (int k = 0; k < 5; k++) drive_line(k, HT, 6'h00, -1, -10);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            hsync_in = 1'b1; vsync_in = 1'b1;
            {r_in, g_in, b_in} = 6'd0;
        end
        // Frame G: closes F with saturated line length
        push_fd(5, 1'b0, 1023, -1, -1, 1'b0, 16'h0);
        frame(6'h00, -1, -1, -1);
        // Frame H: nonzero pixel in blanking at line 2, x=30
        push_fd(VT, 1'b1, -1, -1, -1, 1'b0, 16'h0);
`ifdef MON_BLANK_CHECK_EN
        err_q.push_back(3);
        lk_h = 1'b0;
`else
        lk_h = 1'b1;
`endif
        frame(6'h00, -1, 2, -1);
        // Frame I: closes H (blank pixel never enters the signature);
        // reset pulse at line 8
        push_fd(VT, lk_h, -1, -1, -1, 1'b1, m0);
        frame(6'h00, -1, -1, 8);
        // Frame J: partial frame after reset (lines 9..19 plus closing fall)
        push_fd(12, 1'b0, -1, -1, -1, 1'b0, 16'h0);
        frame(6'h00, -1, -1, -1);
        // Closing vsync of J -> LOCKED again
        push_fd(VT, 1'b1, HT, -1, -1, 1'b0, 16'h0);
        for (int k = 0; k < 3; k++) drive_line(k, HT, 6'h00, -1, -10);

        repeat (10) @(negedge clk);
        chk("frame_done_queue_drained", fd_q.size(), 0);
        chk("err_queue_drained", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
